// File: rtl/bigreg_poll_ctrl.sv
// Sequences read-out of one PS_BIGREG group: wait for VALID, read SAMPLES entries,
// clear the group's fresh bits, then present the assembled register to the consumer.
module bigreg_poll_ctrl #(
    parameter int MEM_SIZE      = 256,
    parameter int WD_DATA_WIDTH = 16,
    parameter int BASE_ID       = 33,
    parameter int SAMPLES       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [MEM_SIZE-1:0]                fresh_bits,
    output logic                               rd_en,
    output logic [$clog2(MEM_SIZE)-1:0]        rd_id,
    input  logic [WD_DATA_WIDTH-1:0]           rd_data,
    output logic                               clr_en,
    output logic [$clog2(MEM_SIZE)-1:0]        clr_id,
    output logic                               busy,
    output logic [SAMPLES*WD_DATA_WIDTH-1:0]   data_out,
    output logic                               valid_out,
    input  logic                               ready_in,
    output logic                               partial
);

    localparam int IDW      = $clog2(MEM_SIZE);
    localparam int CW       = $clog2(SAMPLES + 1);
    localparam int VALID_ID = BASE_ID + SAMPLES;
    localparam int DW       = SAMPLES * WD_DATA_WIDTH;

    if (VALID_ID >= MEM_SIZE) begin : g_bad_valid_id
        $error("bigreg_poll_ctrl: BASE_ID+SAMPLES must be below MEM_SIZE");
    end

    typedef enum logic [1:0] {IDLE, READ, CLEAR, OUT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            last;
    logic [IDW-1:0]  grp_id;
    logic            acc;
    logic [DW-1:0]   asm_reg;

    assign last      = (cnt == CW'(SAMPLES));
    assign grp_id    = IDW'(BASE_ID) + IDW'(cnt);
    assign busy      = (state != IDLE);
    assign valid_out = (state == OUT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_en     = 1'b0;
        rd_id     = '0;
        clr_en    = 1'b0;
        clr_id    = '0;
        case (state)
            IDLE: begin
                if (fresh_bits[VALID_ID]) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                if (last) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else begin
                    rd_en   = 1'b1;
                    rd_id   = grp_id;
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                clr_id = grp_id;
                if (last) begin
                    state_nxt = OUT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            OUT: begin
                if (ready_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Read data trails rd_en by one cycle, so word cnt-1 is captured at cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 1'b0;
            asm_reg  <= '0;
            data_out <= '0;
            partial  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fresh_bits[VALID_ID]) acc <= 1'b0;
                end
                READ: begin
                    if (!last) acc <= acc | ~fresh_bits[grp_id];
                    if (cnt != '0)
                        asm_reg[WD_DATA_WIDTH*(int'(cnt)-1) +: WD_DATA_WIDTH] <= rd_data;
                end
                CLEAR: begin
                    if (last) begin
                        data_out <= asm_reg;
                        partial  <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bigreg_poll_ctrl.sv
// Bench for bigreg_poll_ctrl: mem_map model, cycle-offset behavioural model with
// per-cycle compare, plus directed scenarios with literal expectations.
module tb_bigreg_poll_ctrl;

    localparam int B = 33;
    localparam int S = 16;
    localparam int V = B + S;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] fresh_bits = '0;
    logic [255:0] set_req = '0;
    logic [255:0] clr_mask;
    logic [15:0]  mem [256];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    logic         rd_en, clr_en, busy, valid_out, partial, ready_in;
    logic [7:0]   rd_id, clr_id;
    logic [15:0]  rd_data;
    logic [255:0] data_out;

    logic         rd_en2, clr_en2, busy2, valid2, partial2;
    logic [7:0]   rd_id2, clr_id2;
    logic [15:0]  rd_data2;
    logic [255:0] data2;

    int rdq[$], clq[$], rdq2[$], clq2[$];

    bigreg_poll_ctrl #(.MEM_SIZE(256), .WD_DATA_WIDTH(16), .BASE_ID(B), .SAMPLES(S)) dut (
        .clk(clk), .rst(rst), .fresh_bits(fresh_bits), .rd_en(rd_en), .rd_id(rd_id),
        .rd_data(rd_data), .clr_en(clr_en), .clr_id(clr_id), .busy(busy),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .partial(partial)
    );

    bigreg_poll_ctrl #(.MEM_SIZE(256), .WD_DATA_WIDTH(16), .BASE_ID(1), .SAMPLES(16)) dut_seed (
        .clk(clk), .rst(rst), .fresh_bits(fresh_bits), .rd_en(rd_en2), .rd_id(rd_id2),
        .rd_data(rd_data2), .clr_en(clr_en2), .clr_id(clr_id2), .busy(busy2),
        .data_out(data2), .valid_out(valid2), .ready_in(ready_in), .partial(partial2)
    );

    always #5 clk = ~clk;

    // mem_map model: one-cycle read latency, fresh bits set by PS writes, cleared by strobes
    always_comb begin
        clr_mask = '0;
        if (clr_en)  clr_mask[clr_id]  = 1'b1;
        if (clr_en2) clr_mask[clr_id2] = 1'b1;
    end

    always @(posedge clk) begin
        fresh_bits <= (fresh_bits & ~clr_mask) | set_req;
        rd_data    <= rd_en  ? mem[rd_id]  : 16'hdead;
        rd_data2   <= rd_en2 ? mem[rd_id2] : 16'hdead;
        cyc        <= cyc + 1;
        if (rd_en)   rdq.push_back(int'(rd_id));
        if (clr_en)  clq.push_back(int'(clr_id));
        if (rd_en2)  rdq2.push_back(int'(rd_id2));
        if (clr_en2) clq2.push_back(int'(clr_id2));
    end

    // Model: k = cycles since transaction start (0 = idle). 1..S+1 read phase,
    // S+2..2S+2 clear phase, >= 2S+3 output phase.
    int           k = 0;
    logic [15:0]  words [S];
    logic [255:0] exp_data = '0;
    logic         exp_part = 1'b0;
    logic         acc = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= 0;
            exp_data <= '0;
            exp_part <= 1'b0;
            acc      <= 1'b0;
        end else begin
            if (k >= 1 && k <= S) begin
                words[k-1] <= mem[B+k-1];
                if (!fresh_bits[B+k-1]) acc <= 1'b1;
            end
            if (k == 0) begin
                if (fresh_bits[V]) begin
                    k   <= 1;
                    acc <= 1'b0;
                end
            end else if (k < 2*S+3) begin
                if (k == 2*S+2) begin
                    for (int i = 0; i < S; i++) exp_data[16*i +: 16] <= words[i];
                    exp_part <= acc;
                end
                k <= k + 1;
            end else if (ready_in) begin
                k <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_busy",    busy,      k != 0);
        chk("m_rd_en",   rd_en,     k >= 1 && k <= S);
        chk("m_rd_id",   rd_id,     (k >= 1 && k <= S) ? B + k - 1 : 0);
        chk("m_clr_en",  clr_en,    k >= S+2 && k <= 2*S+2);
        chk("m_clr_id",  clr_id,    (k >= S+2 && k <= 2*S+2) ? B + k - S - 2 : 0);
        chk("m_valid",   valid_out, k >= 2*S+3);
        chk("m_partial", partial,   exp_part);
        chk("m_data",    data_out,  exp_data);
    end

    task automatic mask_range(input int lo, input int hi, output logic [255:0] m);
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    endtask

    task automatic start(input logic [255:0] m, output int t);
        @(negedge clk);
        set_req = m;
        @(negedge clk);
        set_req = '0;
        t = cyc;
    endtask

    task automatic wait_valid(input bit seed, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (seed ? valid2 : valid_out) begin
                at = cyc;
                break;
            end
        end
        chk("valid_timeout", at < 0, 0);
    endtask

    task automatic check_words(input string nm, input logic [255:0] d, input int base_val);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_w%0d", nm, i), d[16*i +: 16], base_val + i);
    endtask

    task automatic check_log(input string nm, input int q[$], input int lo, input int hi);
        chk({nm, "_len"}, q.size(), hi - lo + 1);
        for (int i = 0; i < q.size() && i <= hi - lo; i++)
            chk($sformatf("%s_%0d", nm, i), q[i], lo + i);
    endtask

    initial begin
        logic [255:0] m;
        int t, at, t2;
        bit found;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h5a5a;
        for (int i = 0; i < 16; i++) begin
            mem[B+i] = 16'h1000 + 16'(i);
            mem[1+i] = 16'h2000 + 16'(i);
        end
        ready_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_id", rd_id, 0);
        chk("rst_clr_en", clr_en, 0);
        chk("rst_clr_id", clr_id, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_partial", partial, 0);
        chk("rst_data", data_out, 0);
        rst = 1'b0;
        ready_in = 1'b1;

        // all fresh, consumer ready
        rdq.delete(); clq.delete();
        mask_range(B, V, m);
        start(m, t);
        wait_valid(0, at);
        chk("t1_latency", at - t, 35);
        check_words("t1", data_out, 'h1000);
        chk("t1_partial", partial, 0);
        @(negedge clk);
        chk("t1_valid_after", valid_out, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_hold_w5", data_out[95:80], 16'h1005);
        check_log("t1_rd", rdq, 33, 48);
        check_log("t1_clr", clq, 33, 49);

        // id 40 stale
        mask_range(B, V, m);
        m[40] = 1'b0;
        start(m, t);
        wait_valid(0, at);
        chk("t2_latency", at - t, 35);
        chk("t2_partial", partial, 1);
        check_words("t2", data_out, 'h1000);
        @(negedge clk);

        // consumer stalls 10 cycles
        ready_in = 1'b0;
        mask_range(B, V, m);
        start(m, t);
        wait_valid(0, at);
        repeat (10) begin
            @(negedge clk);
            chk("t3_valid_hold", valid_out, 1);
            chk("t3_busy_hold", busy, 1);
        end
        chk("t3_partial", partial, 0);
        check_words("t3", data_out, 'h1000);
        ready_in = 1'b1;
        @(negedge clk);
        chk("t3_valid_done", valid_out, 0);
        chk("t3_busy_done", busy, 0);

        // VALID re-written during OUT -> back-to-back transaction
        ready_in = 1'b0;
        mask_range(B, V, m);
        start(m, t);
        wait_valid(0, at);
        mask_range(V, V, m);
        start(m, t2);
        ready_in = 1'b1;
        @(negedge clk);
        chk("t4_idle", busy, 0);
        @(negedge clk);
        chk("t4_b2b_rd_en", rd_en, 1);
        chk("t4_b2b_rd_id", rd_id, 33);
        wait_valid(0, at);
        chk("t4_second_partial", partial, 1);
        @(negedge clk);

        // reset during CLEAR cnt=5
        mask_range(B, V, m);
        start(m, t);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clr_en && clr_id == 8'd38) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_reach_clear5", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_clr_en", clr_en, 0);
        chk("t5_clr_id", clr_id, 0);
        chk("t5_valid", valid_out, 0);
        chk("t5_data", data_out, 0);
        chk("t5_partial", partial, 0);
        @(negedge clk);
        chk("t5_clr_en_held", clr_en, 0);
        rst = 1'b0;
        wait_valid(0, at);
        check_words("t5", data_out, 'h1000);
        chk("t5_partial_rerun", partial, 1);
        @(negedge clk);

        // seed group instance
        rdq2.delete(); clq2.delete();
        mask_range(1, 17, m);
        start(m, t);
        wait_valid(1, at);
        chk("t6_latency", at - t, 35);
        check_words("t6", data2, 'h2000);
        chk("t6_partial", partial2, 0);
        @(negedge clk);
        chk("t6_busy_after", busy2, 0);
        check_log("t6_rd", rdq2, 1, 16);
        check_log("t6_clr", clq2, 1, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bigreg_poll_ctrl.md
# bigreg_poll_ctrl

Controller that sequences the read-out of one PS_BIGREG group in the AXI memory map, e.g. seeds, channel mux or SDC. It waits for the processor to write the group's valid entry. It then reads the group's SAMPLES 16-bit entries through the mem_map read port and assembles them into one wide register. It clears the group's fresh bits and hands the register to the RTL consumer through a valid/ready handshake. One instance sits between the mem_map and each PS_BIGREG consumer.

## Interface
Parameters:
- MEM_SIZE, 256, number of mem_map entries
- WD_DATA_WIDTH, 16, data bits per mem_map entry
- BASE_ID, 33, index of the group's first entry (SDC_BASE_ID)
- SAMPLES, 16, entries per group. The valid entry's index is VALID_ID = BASE_ID+SAMPLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- fresh_bits  in  MEM_SIZE  per-entry "PS has written, RTL not yet consumed" flags
- rd_en  out  1  mem_map read strobe
- rd_id  out  $clog2(MEM_SIZE)  mem_map read index
- rd_data  in  WD_DATA_WIDTH  read data; valid exactly 1 cycle after rd_en
- clr_en  out  1  fresh-bit clear strobe
- clr_id  out  $clog2(MEM_SIZE)  index whose fresh bit is cleared
- busy  out  1  transaction in progress; the mem_map answers PS writes to BASE_ID..VALID_ID with SLVERR while high
- data_out  out  SAMPLES*WD_DATA_WIDTH  assembled register; entry i occupies [WD_DATA_WIDTH*i +: WD_DATA_WIDTH]
- valid_out  out  1  data_out valid
- ready_in  in  1  consumer accepts data_out
- partial  out  1  qualifies valid_out: at least one base entry was not fresh when read

## Operation
States: IDLE, READ, CLEAR, OUT.
- **IDLE**
  - busy=0, no strobes.
  - If fresh_bits[VALID_ID]=1, go to READ with cnt=0 and the partial accumulator cleared.
- **READ** (SAMPLES+1 cycles, cnt=0..SAMPLES)
  - For cnt<SAMPLES: rd_en=1, rd_id=BASE_ID+cnt. Also OR ~fresh_bits[BASE_ID+cnt] into the partial accumulator.
  - For cnt≥1: rd_data is written into word cnt-1 of an internal shift/assembly register.
  - At cnt=SAMPLES, go to CLEAR with cnt=0.
- **CLEAR** (SAMPLES+1 cycles, cnt=0..SAMPLES)
  - clr_en=1, clr_id=BASE_ID+cnt. The valid entry is cleared last.
  - At cnt=SAMPLES, load data_out from the assembly register and load partial from the accumulator, then go to OUT.
- **OUT**
  - valid_out=1. data_out and partial are held stable.
  - When valid_out&&ready_in, go to IDLE.
- busy=1 in READ, CLEAR and OUT.
- data_out holds its value after the handshake and is updated only at the next CLEAR→OUT transition.
- rd_id and clr_id are 0 whenever their strobe is low.
- Width rule: BASE_ID+cnt is computed in $clog2(MEM_SIZE) bits. VALID_ID < MEM_SIZE is required and checked by an elaboration-time assertion.

## Timing
- Reset values:
  - state=IDLE
  - busy=0, rd_en=0, rd_id=0, clr_en=0, clr_id=0
  - data_out=0, valid_out=0, partial=0
- Latency: fresh_bits[VALID_ID] is first high in IDLE at cycle t.
  - READ occupies t+1..t+SAMPLES+1.
  - CLEAR occupies t+SAMPLES+2..t+2*SAMPLES+2.
  - valid_out rises at t+2*SAMPLES+3, which is t+35 for SAMPLES=16.
- ready_in high before valid_out rises completes the handshake in the first OUT cycle. IDLE is entered the next cycle.
- Back-to-back: if fresh_bits[VALID_ID] is already high in the IDLE cycle after the handshake, READ starts the following cycle. Minimum period is 2*SAMPLES+4 cycles.
- fresh_bits[VALID_ID] falling during READ/CLEAR (e.g. mem_map reset) does not abort; the transaction completes.
- fresh bits of the group are not sampled outside IDLE/READ.
- rst asserted mid-operation: all outputs return to reset values asynchronously and no further strobes are issued. Any uncleared fresh bits remain set, so the transaction reruns after reset if VALID is still fresh.
- ready_in while not in OUT is ignored.

## Test plan
- All 16 base entries fresh with values 0x1000+i, VALID fresh at t -> 16 reads ids 33..48, clears ids 33..49 in order, valid_out at t+35, data_out word i = 0x1000+i, partial=0.
- Same as above but fresh bit of id 40 low -> partial=1 with valid_out; data still the mem_map contents.
- ready_in low for 10 cycles in OUT -> valid_out, data_out and busy held stable; handshake on the cycle ready rises; IDLE next cycle.
- VALID re-written (fresh) during OUT, ready held high -> second transaction's READ starts exactly 2 cycles after the first handshake.
- rst pulse during CLEAR cnt=5 -> all outputs 0 immediately; clr_en stops. After release with VALID still fresh, a full transaction reruns and delivers correct data.
- Parameter run BASE_ID=1, SAMPLES=16 (seed group) -> reads 1..16, clears 1..17, latency 35.
